add_round_key: RTL
==================

ADD_ROUND_KEY -- requirements
Module: add_round_key

Interface
REQ-001 The block SHALL have parameter STATE_ADDR, default 32, SRAM address of the 128-bit AES state word.
REQ-002 The block SHALL have parameter KEY_BASE_ADDR, default 48, SRAM address of the round-0 key; round r key is at KEY_BASE_ADDR + 16*r.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addkey_enable  input  1  start request; sampled only in IDLE.
REQ-006 round  input  4  round number; latched on the start edge.
REQ-007 sramReadValue  input  128  SRAM read data, valid the cycle after sramRead.
REQ-008 sramWriteValue  output  128  SRAM write data.
REQ-009 sramRead / sramWrite  output  1 each  SRAM strobes.
REQ-010 sramAddr  output  16  SRAM address.
REQ-011 sramDump, sramInit  output  1 each  and sramDumpNum, sramInitNum  output  3 each; all tied to 0.
REQ-012 addkey_finished  output  1  one-cycle done pulse.
REQ-013 addkey_error  output  1  one-cycle pulse when round > 10.

Function
REQ-014 The FSM SHALL have the states IDLE, SADDR, SREAD, SLATCH, KADDR, KREAD, KLATCH, WADDR, WRITE, DONE.
REQ-015 In IDLE with addkey_enable=1, the FSM SHALL go to SADDR and latch round; addkey_enable is ignored in all other states.
REQ-016 The FSM SHALL advance one state per cycle: SADDR->SREAD->SLATCH->KADDR->KREAD->KLATCH->WADDR->WRITE->DONE->IDLE.
REQ-017 SADDR and SREAD SHALL drive sramAddr=STATE_ADDR, with sramRead=1 in SREAD only.
REQ-018 The state word SHALL be registered from sramReadValue on the edge leaving SLATCH.
REQ-019 KADDR and KREAD SHALL drive sramAddr=KEY_BASE_ADDR+{round,4'b0}, computed in 16 bits with wrap-around ignored, and SHALL drive sramRead=1 in KREAD only.
REQ-020 On the edge leaving KLATCH, the result register SHALL load stateword XOR sramReadValue, a full 128-bit bitwise XOR with no byte reordering.
REQ-021 WADDR and WRITE SHALL drive sramAddr=STATE_ADDR with sramWriteValue=result, and sramWrite=1 in WRITE only.
REQ-022 addkey_finished SHALL be 1 exactly in DONE, 9 cycles after the start edge.
REQ-023 If the latched round > 10, the FSM SHALL go SADDR->DONE directly with no read or write, and SHALL assert addkey_error together with addkey_finished in DONE.
REQ-024 In every state not listed above, all strobes and sramAddr SHALL be 0.
REQ-025 addkey_enable held high through DONE SHALL restart only after the FSM returns to IDLE, giving a minimum 10-cycle period.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, clear the state, result and round registers, and drive every output to 0, including mid-operation with no partial write.
REQ-027 After rst deasserts, the first start SHALL require a fresh addkey_enable sampled in IDLE.

Configuration
REQ-028 With ADDROUNDKEY_WRGATE_EN defined, sramWriteValue SHALL be 0 outside WADDR/WRITE.
REQ-029 Without ADDROUNDKEY_WRGATE_EN, sramWriteValue SHALL continuously reflect the result register.

Structure
REQ-030 Package aes_pkg SHALL hold the state enum typedef, STATE_ADDR and KEY_BASE_ADDR defaults, and ROUND_MAX=10.
REQ-031 The design SHALL be a single module with no sub-module; the XOR is too small to warrant one.

Verification
REQ-032 Round 0, SRAM[32]=3243f6a8885a308d313198a2e0370734, SRAM[48]=2b7e151628aed2a6abf7158809cf4f3c -> SRAM[32]=193de3bea0f4e22b9ac68d2ae9f84808; finished pulses 9 cycles after start.
REQ-033 Round 10, key 0xFF..FF at address 208 -> reads at 32 then 208; SRAM[32] is bitwise-inverted; one write.
REQ-034 Round 11 -> no sramRead or sramWrite; finished=1 and error=1 in the same single cycle.
REQ-035 rst asserted during KREAD -> all outputs 0 the same cycle; SRAM[32] unchanged; IDLE after release.
REQ-036 addkey_enable held high for 30 cycles -> exactly 3 finished pulses, 10 cycles apart; enable pulses mid-operation are ignored.
REQ-037 With and without ADDROUNDKEY_WRGATE_EN -> sramWriteValue is 0 versus the result in DONE/IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES AddRoundKey definitions: FSM state encoding, default SRAM map and round limit.
package aes_pkg;

  localparam int ADDR_W            = 16;
  localparam int DATA_W            = 128;
  localparam int STATE_ADDR_DEF    = 32;
  localparam int KEY_BASE_ADDR_DEF = 48;
  localparam int ROUND_MAX         = 10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SADDR  = 4'd1,
    SREAD  = 4'd2,
    SLATCH = 4'd3,
    KADDR  = 4'd4,
    KREAD  = 4'd5,
    KLATCH = 4'd6,
    WADDR  = 4'd7,
    WRITE  = 4'd8,
    DONE   = 4'd9
  } ark_state_t;

endpackage

// File: rtl/add_round_key.sv
// AES AddRoundKey engine: reads the state word and round key from SRAM, XORs them, writes back.
// Optional ADDROUNDKEY_WRGATE_EN: drive sramWriteValue only during WADDR/WRITE.
module add_round_key
  import aes_pkg::*;
#(
  parameter int STATE_ADDR    = STATE_ADDR_DEF,
  parameter int KEY_BASE_ADDR = KEY_BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addkey_enable,
  input  logic [3:0]        round,
  input  logic [DATA_W-1:0] sramReadValue,
  output logic [DATA_W-1:0] sramWriteValue,
  output logic              sramRead,
  output logic              sramWrite,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              sramDump,
  output logic              sramInit,
  output logic [2:0]        sramDumpNum,
  output logic [2:0]        sramInitNum,
  output logic              addkey_finished,
  output logic              addkey_error
);

  ark_state_t        r_state;
  ark_state_t        w_next;
  logic [3:0]        r_round;
  logic [DATA_W-1:0] r_stateword;
  logic [DATA_W-1:0] r_result;
  logic [ADDR_W-1:0] w_state_addr;
  logic [ADDR_W-1:0] w_key_addr;
  logic              w_bad_round;

  assign w_state_addr = ADDR_W'(STATE_ADDR);
  // 16-bit sum; any carry out of the top bit is simply dropped.
  assign w_key_addr   = ADDR_W'(KEY_BASE_ADDR) + {8'd0, r_round, 4'd0};
  assign w_bad_round  = (r_round > 4'(ROUND_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_round     <= 4'd0;
      r_stateword <= '0;
      r_result    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && addkey_enable) begin
        r_round <= round;
      end
      if (r_state == SLATCH) begin
        r_stateword <= sramReadValue;
      end
      if (r_state == KLATCH) begin
        r_result <= r_stateword ^ sramReadValue;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = addkey_enable ? SADDR : IDLE;
      SADDR:   w_next = w_bad_round ? DONE : SREAD;
      SREAD:   w_next = SLATCH;
      SLATCH:  w_next = KADDR;
      KADDR:   w_next = KREAD;
      KREAD:   w_next = KLATCH;
      KLATCH:  w_next = WADDR;
      WADDR:   w_next = WRITE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    sramRead        = 1'b0;
    sramWrite       = 1'b0;
    sramAddr        = '0;
    addkey_finished = 1'b0;
    addkey_error    = 1'b0;
    case (r_state)
      SADDR:  sramAddr = w_state_addr;
      SREAD: begin
        sramAddr = w_state_addr;
        sramRead = 1'b1;
      end
      KADDR:  sramAddr = w_key_addr;
      KREAD: begin
        sramAddr = w_key_addr;
        sramRead = 1'b1;
      end
      WADDR:  sramAddr = w_state_addr;
      WRITE: begin
        sramAddr  = w_state_addr;
        sramWrite = 1'b1;
      end
      DONE: begin
        addkey_finished = 1'b1;
        addkey_error    = w_bad_round;
      end
      default: ;
    endcase
  end

`ifdef ADDROUNDKEY_WRGATE_EN
  assign sramWriteValue = (r_state == WADDR || r_state == WRITE) ? r_result : '0;
`else
  assign sramWriteValue = r_result;
`endif

  assign sramDump    = 1'b0;
  assign sramInit    = 1'b0;
  assign sramDumpNum = 3'd0;
  assign sramInitNum = 3'd0;

endmodule
